// File: rtl/led_freq_detector.sv
// Half-period meter for a slow square wave: synchronises the input, times the gap between
// successive edges and classifies it into the 10/5/2/1 Hz blinker bands with a lock flag.
module led_freq_detector #(
  parameter  int unsigned g_COUNT_10HZ = 1250000,
  parameter  int unsigned g_COUNT_5HZ  = 2500000,
  parameter  int unsigned g_COUNT_2HZ  = 6250000,
  parameter  int unsigned g_COUNT_1HZ  = 12500000,
  parameter  int unsigned g_TOL_SHIFT  = 3,
  parameter  int unsigned g_LOCK_COUNT = 4,
  localparam int unsigned c_TIMEOUT    = 2 * g_COUNT_1HZ,
  localparam int unsigned c_W          = $clog2(c_TIMEOUT + 1)
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  input  logic           i_Sig,
  output logic           o_Valid,
  output logic [c_W-1:0] o_Half_Period,
  output logic [2:0]     o_Freq_Code,
  output logic           o_Locked
);

  localparam int unsigned c_LW = $clog2(g_LOCK_COUNT + 1);
  localparam logic [c_LW-1:0] c_LOCK = c_LW'(g_LOCK_COUNT);
  localparam logic [c_W-1:0]  c_TMO  = c_W'(c_TIMEOUT);

  typedef enum logic {ST_IDLE, ST_MEAS} t_state;

  t_state          r_State;
  logic            r_S1, r_S2, r_S3;
  logic [c_W-1:0]  r_Cnt;
  logic [c_LW-1:0] r_Match;

  logic            w_Edge;
  logic [2:0]      w_Code;
  logic [c_LW-1:0] w_Match_Next;

  // One extra bit keeps the subtraction free of wrap-around for any counter value.
  function automatic logic band_match(input logic [c_W-1:0] h, input int unsigned c);
    logic [c_W:0] v_h, v_c, v_tol, v_diff;
    v_h    = {1'b0, h};
    v_c    = (c_W + 1)'(c);
    v_tol  = v_c >> g_TOL_SHIFT;
    v_diff = (v_h >= v_c) ? (v_h - v_c) : (v_c - v_h);
    return (v_diff <= v_tol);
  endfunction

  assign w_Edge = r_S2 ^ r_S3;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_Code = 3'd0;
    if      (band_match(r_Cnt, g_COUNT_10HZ)) w_Code = 3'd4;
    else if (band_match(r_Cnt, g_COUNT_5HZ))  w_Code = 3'd3;
    else if (band_match(r_Cnt, g_COUNT_2HZ))  w_Code = 3'd2;
    else if (band_match(r_Cnt, g_COUNT_1HZ))  w_Code = 3'd1;
  end

  always_comb begin
    w_Match_Next = '0;
    if (w_Code != 3'd0) begin
      if (w_Code == o_Freq_Code)
        w_Match_Next = (r_Match >= c_LOCK) ? c_LOCK : r_Match + c_LW'(1);
      else
        w_Match_Next = c_LW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_S1          <= 1'b0;
      r_S2          <= 1'b0;
      r_S3          <= 1'b0;
      r_State       <= ST_IDLE;
      r_Cnt         <= '0;
      r_Match       <= '0;
      o_Valid       <= 1'b0;
      o_Half_Period <= '0;
      o_Freq_Code   <= 3'd0;
      o_Locked      <= 1'b0;
    end else begin
      r_S1    <= i_Sig;
      r_S2    <= r_S1;
      r_S3    <= r_S2;
      o_Valid <= 1'b0;
      case (r_State)
        ST_IDLE: begin
          r_Cnt <= '0;
          if (w_Edge) begin
            r_Cnt   <= c_W'(1);
            r_State <= ST_MEAS;
          end
        end
        ST_MEAS: begin
          if (w_Edge) begin
            o_Half_Period <= r_Cnt;
            o_Valid       <= 1'b1;
            o_Freq_Code   <= w_Code;
            r_Match       <= w_Match_Next;
            o_Locked      <= (w_Match_Next >= c_LOCK);
            r_Cnt         <= c_W'(1);
          end else if (r_Cnt >= c_TMO) begin
            // Input went quiet: drop the band and lock but keep the last measurement.
            r_State     <= ST_IDLE;
            r_Cnt       <= '0;
            r_Match     <= '0;
            o_Freq_Code <= 3'd0;
            o_Locked    <= 1'b0;
          end else begin
            r_Cnt <= r_Cnt + c_W'(1);
          end
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_freq_detector.sv
// Bench for led_freq_detector: directed scenarios plus randomized half-periods, checked
// against a toggle-interval reference model and a queue of expected measurements.
module tb_led_freq_detector;

  localparam int C10 = 5, C5 = 10, C2 = 25, C1 = 50, TS = 3, LK = 4, TMO = 100, W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         sig;
  logic         o_valid;
  logic [W-1:0] o_half;
  logic [2:0]   o_code;
  logic         o_locked;

  always #5 clk = ~clk;

  led_freq_detector #(
    .g_COUNT_10HZ(C10), .g_COUNT_5HZ(C5), .g_COUNT_2HZ(C2), .g_COUNT_1HZ(C1),
    .g_TOL_SHIFT(TS), .g_LOCK_COUNT(LK)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Sig(sig),
    .o_Valid(o_valid), .o_Half_Period(o_half), .o_Freq_Code(o_code), .o_Locked(o_locked)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h;
    int code;
    bit locked;
    int t;
  } exp_t;

  exp_t q[$];

  bit m_active = 1'b0;
  int m_last   = 0;
  int m_code   = 0;
  int m_match  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit near(input int h, input int c);
    int d;
    d = h - c;
    if (d < 0) d = -d;
    return d <= (c >> TS);
  endfunction

  function automatic int band(input int h);
    if (near(h, C10)) return 4;
    if (near(h, C5))  return 3;
    if (near(h, C2))  return 2;
    if (near(h, C1))  return 1;
    return 0;
  endfunction

  // Reference model driven by the bench's own toggle times.
  task automatic model_toggle();
    int iv, c;
    iv     = cyc - m_last;
    m_last = cyc;
    if (m_active && iv > TMO) begin
      m_active = 1'b0;
      m_code   = 0;
      m_match  = 0;
    end
    if (!m_active) begin
      m_active = 1'b1;
    end else begin
      c = band(iv);
      if (c == 0)            m_match = 0;
      else if (c == m_code)  m_match = (m_match + 1 > LK) ? LK : m_match + 1;
      else                   m_match = 1;
      m_code = c;
      q.push_back('{iv, c, (m_match >= LK), cyc});
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_code   = 0;
    m_match  = 0;
    q.delete();
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (o_valid === 1'b1) begin
      check("valid_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("half_period", 32'(o_half), 32'(e.h));
        check("freq_code", 32'(o_code), 32'(e.code));
        check("locked", 32'(o_locked), 32'(e.locked));
        check("valid_latency", 32'((cyc - e.t) inside {[2:4]}), 32'd1);
      end
    end
  endtask

  task automatic half(input int n);
    sig = ~sig;
    model_toggle();
    repeat (n) step();
  endtask

  function automatic int pick();
    case ($urandom_range(0, 4))
      0:       return C10;
      1:       return C5 + $urandom_range(0, 4) - 2;
      2:       return C2 + $urandom_range(0, 8) - 4;
      3:       return C1 + $urandom_range(0, 16) - 8;
      default: return $urandom_range(3, 70);
    endcase
  endfunction

  int bnd[14] = '{9, 11, 8, 12, 22, 28, 21, 29, 44, 56, 43, 57, 4, 6};

  initial begin
    int n;
    // 1. reset and quiet input
    rst = 1'b1;
    sig = 1'b0;
    repeat (2) step();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_half", 32'(o_half), 32'd0);
    check("rst_code", 32'(o_code), 32'd0);
    check("rst_locked", 32'(o_locked), 32'd0);
    rst = 1'b0;
    repeat (150) step();
    check("quiet_no_valid", 32'(q.size()), 32'd0);

    // 2. 10 Hz band
    repeat (6) half(C10);
    check("t2_pending", 32'(q.size()), 32'd0);
    check("t2_code", 32'(o_code), 32'd4);
    check("t2_locked", 32'(o_locked), 32'd1);

    // 3. tolerance hit, then an off-band period
    repeat (3) half(26);
    check("t3_code26", 32'(o_code), 32'd2);
    repeat (2) half(30);
    check("t3_code30", 32'(o_code), 32'd0);
    check("t3_locked30", 32'(o_locked), 32'd0);

    // 4. lock at 5 Hz, then move to 1 Hz
    repeat (6) half(C5);
    check("t4_lock5", 32'(o_locked), 32'd1);
    check("t4_code5", 32'(o_code), 32'd3);
    repeat (2) half(C1);
    check("t4_unlocked", 32'(o_locked), 32'd0);
    check("t4_code1", 32'(o_code), 32'd1);
    repeat (3) half(C1);
    check("t4_relock", 32'(o_locked), 32'd1);

    // 5. timeout after the input stops
    repeat (40) step();
    check("t5_before_tmo_locked", 32'(o_locked), 32'd1);
    check("t5_before_tmo_code", 32'(o_code), 32'd1);
    repeat (20) step();
    check("t5_tmo_code", 32'(o_code), 32'd0);
    check("t5_tmo_locked", 32'(o_locked), 32'd0);
    check("t5_tmo_half_held", 32'(o_half), 32'd50);
    half(C5);
    check("t5_restart_no_valid", 32'(q.size()), 32'd0);
    repeat (2) half(C5);
    check("t5_code_after", 32'(o_code), 32'd3);

    // 6. reset in the middle of a half-period while locked
    repeat (5) half(C5);
    if (sig) half(C5);
    check("t6_locked_before", 32'(o_locked), 32'd1);
    rst = 1'b1;
    step();
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_half", 32'(o_half), 32'd0);
    check("t6_rst_code", 32'(o_code), 32'd0);
    check("t6_rst_locked", 32'(o_locked), 32'd0);
    rst = 1'b0;
    model_reset();
    half(C5);
    check("t6_first_edge_only", 32'(o_valid), 32'd0);
    half(C5);
    check("t6_code_after", 32'(o_code), 32'd3);
    check("t6_locked_after", 32'(o_locked), 32'd0);

    // Band edges, then randomized runs of repeated half-periods
    foreach (bnd[i]) half(bnd[i]);
    repeat (25) begin
      n = pick();
      repeat ($urandom_range(1, 6)) half(n);
    end
    repeat (6) step();
    check("final_pending", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
